// File: rtl/uart_pkg.sv
// Shared UART definitions: setup-word layout, receiver states and small helpers.
package uart_pkg;

    localparam int SETUP_W     = 31;
    localparam int CPB_W       = 24;
    localparam int DBITS_HI    = 29;
    localparam int DBITS_LO    = 28;
    localparam int STOP2_BIT   = 27;
    localparam int PAR_EN_BIT  = 26;
    localparam int PAR_FIX_BIT = 25;
    localparam int PAR_ODD_BIT = 24;

    localparam logic [CPB_W-1:0] MIN_CPB = 24'd4;

    typedef enum logic [2:0] {
        RX_WAIT_IDLE = 3'd0,
        RX_IDLE      = 3'd1,
        RX_START     = 3'd2,
        RX_DATA      = 3'd3,
        RX_PARITY    = 3'd4,
        RX_STOP      = 3'd5,
        RX_STOP2     = 3'd6
    } rx_state_t;

    // Data-bits code to word length: 00=8, 01=7, 10=6, 11=5.
    function automatic logic [3:0] data_bits(input logic [1:0] code);
        logic [3:0] n;
        case (code)
            2'b00:   n = 4'd8;
            2'b01:   n = 4'd7;
            2'b10:   n = 4'd6;
            2'b11:   n = 4'd5;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Very short baud periods cannot place a mid-bit sample; keep a floor.
    function automatic logic [CPB_W-1:0] clamp_cpb(input logic [CPB_W-1:0] raw);
        logic [CPB_W-1:0] c;
        if (raw < MIN_CPB) begin
            c = MIN_CPB;
        end else begin
            c = raw;
        end
        return c;
    endfunction

    // Expected parity bit: fixed value, or data XOR the odd-select bit.
    function automatic logic parity_expected(input logic [7:0] data,
                                             input logic       fixed,
                                             input logic       odd_or_val);
        logic p;
        if (fixed) begin
            p = odd_or_val;
        end else begin
            p = (^data) ^ odd_or_val;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous idle-high UART line.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic rx_async,
    output logic rx_sync
);

    logic meta_r;
    logic sync_r;

    // Resolve metastability; reset to the idle (high) level.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= rx_async;
            sync_r <= meta_r;
        end
    end

    assign rx_sync = sync_r;

endmodule

// File: rtl/rxuart.sv
// UART receiver: oversampled start validation, mid-baud sampling, error flags, break detection.
module rxuart
    import uart_pkg::*;
#(
    parameter logic [30:0] INITIAL_SETUP = 31'd868
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [30:0] i_setup,
    input  logic        i_uart_rx,
    output logic        o_wr,
    output logic [7:0]  o_data,
    output logic        o_parity_err,
    output logic        o_frame_err,
    output logic        o_break
);

    logic             rx_s;
    rx_state_t        state_r, state_n;
    logic [CPB_W-1:0] cnt_r, cnt_n;
    logic [30:0]      setup_r, setup_n;
    logic [7:0]       shreg_r, shreg_n;
    logic [2:0]       bitcnt_r, bitcnt_n;
    logic             par_hi_r, par_hi_n;
    logic             perr_r, perr_n;
    logic             ferr_r, ferr_n;
    logic             wr_r, wr_n;
    logic [7:0]       data_r, data_n;
    logic             out_perr_r, out_perr_n;
    logic             out_ferr_r, out_ferr_n;
    logic             brk_r, brk_n;

    logic [CPB_W-1:0] cpb_m1_s;
    logic [3:0]       nbits_s;
    logic             cnt_zero_s;
    logic             unused_setup_s;

    uart_rx_sync u_sync (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .rx_async (i_uart_rx),
        .rx_sync  (rx_s)
    );

    assign cpb_m1_s       = clamp_cpb(setup_r[CPB_W-1:0]) - 24'd1;
    assign nbits_s        = data_bits(setup_r[DBITS_HI:DBITS_LO]);
    assign cnt_zero_s     = (cnt_r == 24'd0);
    // Bit 30 of the setup word is reserved.
    assign unused_setup_s = setup_r[30];

    // Next-state, baud counter, shift register and output-register logic.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        setup_n    = setup_r;
        shreg_n    = shreg_r;
        bitcnt_n   = bitcnt_r;
        par_hi_n   = par_hi_r;
        perr_n     = perr_r;
        ferr_n     = ferr_r;
        wr_n       = 1'b0;
        data_n     = data_r;
        out_perr_n = out_perr_r;
        out_ferr_n = out_ferr_r;
        brk_n      = brk_r;

        case (state_r)
            RX_WAIT_IDLE: begin
                if (rx_s) begin
                    state_n = RX_IDLE;
                    brk_n   = 1'b0;
                end else begin
                    state_n = RX_WAIT_IDLE;
                end
            end
            RX_IDLE: begin
                if (!rx_s) begin
                    // Start edge: latch the setup for this frame, aim at mid start bit.
                    setup_n  = i_setup;
                    cnt_n    = (clamp_cpb(i_setup[CPB_W-1:0]) >> 1) - 24'd1;
                    shreg_n  = 8'd0;
                    bitcnt_n = 3'd0;
                    par_hi_n = 1'b0;
                    perr_n   = 1'b0;
                    ferr_n   = 1'b0;
                    state_n  = RX_START;
                end else begin
                    state_n = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_zero_s) begin
                    if (rx_s) begin
                        state_n = RX_IDLE;
                    end else begin
                        cnt_n   = cpb_m1_s;
                        state_n = RX_DATA;
                    end
                end else begin
                    cnt_n = cnt_r - 24'd1;
                end
            end
            RX_DATA: begin
                if (cnt_zero_s) begin
                    shreg_n = {rx_s, shreg_r[7:1]};
                    cnt_n   = cpb_m1_s;
                    if ({1'b0, bitcnt_r} == (nbits_s - 4'd1)) begin
                        state_n = setup_r[PAR_EN_BIT] ? RX_PARITY : RX_STOP;
                    end else begin
                        bitcnt_n = bitcnt_r + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_r - 24'd1;
                end
            end
            RX_PARITY: begin
                if (cnt_zero_s) begin
                    par_hi_n = rx_s;
                    perr_n   = (rx_s != parity_expected(shreg_r, setup_r[PAR_FIX_BIT],
                                                        setup_r[PAR_ODD_BIT]));
                    cnt_n    = cpb_m1_s;
                    state_n  = RX_STOP;
                end else begin
                    cnt_n = cnt_r - 24'd1;
                end
            end
            RX_STOP: begin
                if (cnt_zero_s) begin
                    if (!rx_s && (shreg_r == 8'd0) && !par_hi_r) begin
                        // Whole frame low: line break, no word delivered.
                        brk_n   = 1'b1;
                        state_n = RX_WAIT_IDLE;
                    end else if (setup_r[STOP2_BIT]) begin
                        ferr_n  = ~rx_s;
                        cnt_n   = cpb_m1_s;
                        state_n = RX_STOP2;
                    end else begin
                        wr_n       = 1'b1;
                        data_n     = shreg_r >> (4'd8 - nbits_s);
                        out_perr_n = perr_r;
                        out_ferr_n = ~rx_s;
                        state_n    = rx_s ? RX_IDLE : RX_WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt_r - 24'd1;
                end
            end
            RX_STOP2: begin
                if (cnt_zero_s) begin
                    wr_n       = 1'b1;
                    data_n     = shreg_r >> (4'd8 - nbits_s);
                    out_perr_n = perr_r;
                    out_ferr_n = ferr_r | ~rx_s;
                    state_n    = rx_s ? RX_IDLE : RX_WAIT_IDLE;
                end else begin
                    cnt_n = cnt_r - 24'd1;
                end
            end
            default: begin
                state_n = RX_WAIT_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any frame in progress.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r    <= RX_WAIT_IDLE;
            cnt_r      <= 24'd0;
            setup_r    <= INITIAL_SETUP;
            shreg_r    <= 8'd0;
            bitcnt_r   <= 3'd0;
            par_hi_r   <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            wr_r       <= 1'b0;
            data_r     <= 8'd0;
            out_perr_r <= 1'b0;
            out_ferr_r <= 1'b0;
            brk_r      <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            setup_r    <= setup_n;
            shreg_r    <= shreg_n;
            bitcnt_r   <= bitcnt_n;
            par_hi_r   <= par_hi_n;
            perr_r     <= perr_n;
            ferr_r     <= ferr_n;
            wr_r       <= wr_n;
            data_r     <= data_n;
            out_perr_r <= out_perr_n;
            out_ferr_r <= out_ferr_n;
            brk_r      <= brk_n;
        end
    end

    assign o_wr         = wr_r;
    assign o_data       = data_r;
    assign o_parity_err = out_perr_r;
    assign o_frame_err  = out_ferr_r;
    assign o_break      = brk_r;

endmodule

// File: tb/tb_rxuart.sv
// Directed self-checking bench for rxuart.
module tb_rxuart;

    localparam logic [30:0] S_8N1   = 31'h0000_0010;
    localparam logic [30:0] S_7E1   = 31'h1400_0010;
    localparam logic [30:0] S_8N2   = 31'h0800_0010;
    localparam logic [30:0] S_CLAMP = 31'h0000_0001;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [30:0] setup;
    logic        rx;
    logic        wr;
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    logic        brk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cyc   = 0;
    int brk_rise = 0;
    int c0;
    logic brk_prev = 1'b0;

    logic [7:0] d_q[$];
    logic       pe_q[$];
    logic       fe_q[$];

    rxuart dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_setup      (setup),
        .i_uart_rx    (rx),
        .o_wr         (wr),
        .o_data       (data),
        .o_parity_err (perr),
        .o_frame_err  (ferr),
        .o_break      (brk)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every strobed word and the rising edge of the break flag.
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            d_q.push_back(data);
            pe_q.push_back(perr);
            fe_q.push_back(ferr);
            wr_cyc <= cyc;
        end
        if (brk === 1'b1 && brk_prev !== 1'b1) brk_rise <= cyc;
        brk_prev <= brk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qd(input int i);
        return (i < d_q.size()) ? {24'd0, d_q[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qpe(input int i);
        return (i < pe_q.size()) ? {31'd0, pe_q[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qfe(input int i);
        return (i < fe_q.size()) ? {31'd0, fe_q[i]} : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_q();
        d_q.delete();
        pe_q.delete();
        fe_q.delete();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame from a negedge; leaves the line at the last stop-bit level.
    task automatic send_frame(input logic [7:0] d, input int nb, input int cpb,
                              input bit has_par, input logic par,
                              input logic st1, input bit two_stop, input logic st2);
        rx = 1'b0;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            repeat (cpb) @(negedge clk);
        end
        if (has_par) begin
            rx = par;
            repeat (cpb) @(negedge clk);
        end
        rx = st1;
        repeat (cpb) @(negedge clk);
        if (two_stop) begin
            rx = st2;
            repeat (cpb) @(negedge clk);
        end
    endtask

    // Linear directed sequence.
    initial begin
        int lat;
        rx      = 1'b1;
        setup   = S_8N1;
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wr",    {31'd0, wr},   32'd0);
        check("rst_data",  {24'd0, data}, 32'd0);
        check("rst_perr",  {31'd0, perr}, 32'd0);
        check("rst_ferr",  {31'd0, ferr}, 32'd0);
        check("rst_break", {31'd0, brk},  32'd0);
        i_reset = 1'b0;
        idle(10);

        // 8N1 0xA5; stop sample lands 3 + 8 + 9*16 cycles after the drive edge.
        clear_q();
        c0 = cyc;
        send_frame(8'hA5, 8, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("a5_count", d_q.size(), 32'd1);
        check("a5_data",  qd(0),  32'hA5);
        check("a5_perr",  qpe(0), 32'd0);
        check("a5_ferr",  qfe(0), 32'd0);
        lat = wr_cyc - c0;
        check("a5_latency", {31'd0, (lat >= 153 && lat <= 157)}, 32'd1);

        // 7E1 0x41 with good then bad parity.
        setup = S_7E1;
        clear_q();
        send_frame(8'h41, 7, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'h41, 7, 16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("7e1_count", d_q.size(), 32'd2);
        check("7e1_data0", qd(0),  32'h41);
        check("7e1_perr0", qpe(0), 32'd0);
        check("7e1_data1", qd(1),  32'h41);
        check("7e1_perr1", qpe(1), 32'd1);
        check("7e1_ferr1", qfe(1), 32'd0);

        // 8N2 with second stop low, then line held low: no restart until high.
        setup = S_8N2;
        clear_q();
        send_frame(8'h33, 8, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        setup = S_8N1;
        repeat (48) @(negedge clk);
        check("fe_count", d_q.size(), 32'd1);
        check("fe_data",  qd(0),  32'h33);
        check("fe_ferr",  qfe(0), 32'd1);
        check("fe_perr",  qpe(0), 32'd0);
        check("fe_nobrk", {31'd0, brk}, 32'd0);
        idle(16);
        clear_q();
        send_frame(8'hC3, 8, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("c3_count", d_q.size(), 32'd1);
        check("c3_data",  qd(0),  32'hC3);
        check("c3_ferr",  qfe(0), 32'd0);

        // Short low glitch is rejected, then a valid frame follows.
        clear_q();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(200);
        check("glitch_none", d_q.size(), 32'd0);
        send_frame(8'h3C, 8, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("3c_count", d_q.size(), 32'd1);
        check("3c_data",  qd(0), 32'h3C);

        // Baud period below the floor is clamped to 4 clocks.
        setup = S_CLAMP;
        clear_q();
        send_frame(8'h96, 8, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(8);
        setup = S_8N1;
        check("clamp_count", d_q.size(), 32'd1);
        check("clamp_data",  qd(0),  32'h96);
        check("clamp_ferr",  qfe(0), 32'd0);

        // Break: 20 bauds low.
        clear_q();
        c0 = cyc;
        rx = 1'b0;
        repeat (320) @(negedge clk);
        check("brk_nowr", d_q.size(), 32'd0);
        check("brk_high", {31'd0, brk}, 32'd1);
        lat = brk_rise - c0;
        check("brk_rise", {31'd0, (lat >= 153 && lat <= 157)}, 32'd1);
        rx = 1'b1;
        @(negedge clk);
        check("brk_hold1", {31'd0, brk}, 32'd1);
        @(negedge clk);
        check("brk_hold2", {31'd0, brk}, 32'd1);
        @(negedge clk);
        check("brk_clear", {31'd0, brk}, 32'd0);
        idle(20);

        // Reset after four data bits, then a full 0x5A frame.
        clear_q();
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (16) @(negedge clk);
        end
        i_reset = 1'b1;
        rx      = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        idle(40);
        check("rstmid_none", d_q.size(), 32'd0);
        send_frame(8'h5A, 8, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("5a_count", d_q.size(), 32'd1);
        check("5a_data",  qd(0), 32'h5A);

        // Back-to-back 0x00 and 0xFF with a single stop bit between them.
        clear_q();
        send_frame(8'h00, 8, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 8, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("b2b_count", d_q.size(), 32'd2);
        check("b2b_data0", qd(0),  32'h00);
        check("b2b_data1", qd(1),  32'hFF);
        check("b2b_ferr0", qfe(0), 32'd0);
        check("b2b_brk",   {31'd0, brk}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
